// File: rtl/axis_rr_mux.sv
// -----------------------------------------------------------------------------
// axis_rr_mux
//
// Merges NUM_CH AXI-Stream slave channels onto one master stream using
// round-robin arbitration. The master side has a registered output stage:
// a beat accepted on a slave port appears on the master port one cycle
// later. Under continuous m_tready the mux moves one beat per cycle. The
// source channel index of each master beat is placed on m_tid.
//
// Optional feature macro: AXIS_RR_MUX_TLAST_EN
//   When defined, the s_tlast and m_tlast ports exist. The arbiter stays
//   locked to one channel from the first beat of a packet until the tlast
//   beat of that packet is accepted.
//
// Parameters
//   DATA_WIDTH : tdata width per channel and on the master port
//   NUM_CH     : number of slave channels, legal range 2..16
//   ID_W       : width of m_tid (derived, $clog2(NUM_CH))
//
// Ports
//   aclk     in   clock, rising edge
//   aresetn  in   asynchronous active-low reset
//   s_tdata  in   channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid in   per-channel valid
//   s_tready out  per-channel ready; at most one bit set, held 0 during reset
//   s_tlast  in   per-channel end of packet (AXIS_RR_MUX_TLAST_EN only)
//   m_tdata  out  merged data
//   m_tvalid out  merged valid
//   m_tready in   downstream ready
//   m_tid    out  source channel index of m_tdata
//   m_tlast  out  merged end of packet (AXIS_RR_MUX_TLAST_EN only)
// -----------------------------------------------------------------------------
module axis_rr_mux #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_CH     = 4,
  localparam int ID_W       = $clog2(NUM_CH)
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_CH*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_CH-1:0]            s_tvalid,
  output logic [NUM_CH-1:0]            s_tready,
`ifdef AXIS_RR_MUX_TLAST_EN
  input  logic [NUM_CH-1:0]            s_tlast,
  output logic                         m_tlast,
`endif
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  input  logic                         m_tready,
  output logic [ID_W-1:0]              m_tid
);

  logic [ID_W-1:0]   last_grant;
  logic              lock;
  logic              load;
  logic              found;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   idx;
  logic [NUM_CH-1:0] grant;

  // The output register can take a new beat when it is empty or when its
  // current beat leaves this cycle.
  assign load = !m_tvalid || m_tready;

  // Arbitration. The search starts one past the previous winner, so the
  // previous winner has the lowest priority. While a packet is in progress
  // only the owning channel is considered; if that channel is idle the
  // output bubbles rather than letting another channel in.
  // NOTE: every signal assigned in this block gets a default first, so no
  // path through it can leave a value unassigned and infer a latch.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    if (lock) begin
      found = s_tvalid[last_grant];
      sel   = last_grant;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = ID_W'((int'(last_grant) + k) % NUM_CH);
        if (!found && s_tvalid[idx]) begin
          found = 1'b1;
          sel   = idx;
        end
      end
    end
  end

  assign grant    = found ? (NUM_CH'(1) << sel) : '0;
  // Ready is gated by aresetn directly: load is 1 during reset because
  // m_tvalid is cleared, so gating is needed to keep slaves from seeing
  // a handshake while the block is held in reset.
  assign s_tready = (aresetn && load) ? grant : '0;

  // Output stage and arbitration state.
  // NOTE: sequential state is updated with non-blocking assignments so that
  // every register samples values from before the clock edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tid      <= '0;
      last_grant <= ID_W'(NUM_CH - 1);
    end else if (load) begin
      if (found) begin
        m_tvalid   <= 1'b1;
        m_tdata    <= s_tdata[sel*DATA_WIDTH +: DATA_WIDTH];
        m_tid      <= sel;
        last_grant <= sel;
      end else begin
        // Nothing to send: drop valid, keep data/id as they were.
        m_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_RR_MUX_TLAST_EN
  // Packet lock: set by any accepted non-final beat, cleared by the final
  // beat. Once cleared the round-robin search resumes after the owner.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tlast <= 1'b0;
      lock    <= 1'b0;
    end else if (load && found) begin
      m_tlast <= s_tlast[sel];
      lock    <= !s_tlast[sel];
    end
  end
`else
  assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_axis_rr_mux.sv
// -----------------------------------------------------------------------------
// tb_axis_rr_mux
//
// Directed testbench for axis_rr_mux with DATA_WIDTH=32 and NUM_CH=4.
// Inputs change 1 ns after a rising edge. Registered outputs are sampled
// 1 ns after the edge. The combinational s_tready is sampled once the
// inputs have settled. The packet-lock scenario is built only when
// AXIS_RR_MUX_TLAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_axis_rr_mux;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          aclk;
  logic          aresetn;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [IW-1:0] m_tid;
`ifdef AXIS_RR_MUX_TLAST_EN
  logic [N-1:0]  s_tlast;
  logic          m_tlast;
`endif

  logic [DW-1:0] dat [N];

  int checks   = 0;
  int failures = 0;

  axis_rr_mux #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
`ifdef AXIS_RR_MUX_TLAST_EN
    .s_tlast  (s_tlast),
    .m_tlast  (m_tlast),
`endif
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tid    (m_tid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always_comb begin
    s_tdata = '0;
    for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = dat[i];
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic default_data();
    for (int i = 0; i < N; i++) dat[i] = 32'hA000_0000 | DW'(i);
  endtask

  task automatic test_reset();
    aresetn  = 1'b0;
    m_tready = 1'b1;
    s_tvalid = 4'hF;
    repeat (2) tick();
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid); end
    checks++; if (m_tdata !== 32'h0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", m_tdata); end
    checks++; if (m_tid !== 2'd0) begin failures++; $display("FAIL reset_tid got=%0d exp=0", m_tid); end
    checks++; if (s_tready !== 4'b0000) begin failures++; $display("FAIL reset_tready got=%b exp=0000", s_tready); end
`ifdef AXIS_RR_MUX_TLAST_EN
    checks++; if (m_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_tlast); end
`endif
    @(negedge aclk);
    aresetn  = 1'b1;
    s_tvalid = 4'h0;
    #1;
    checks++; if (s_tready !== 4'b0000) begin failures++; $display("FAIL idle_tready got=%b exp=0000", s_tready); end
  endtask

  // All channels valid: 0,1,2,3,0,... with no bubbles, starting at channel 0.
  task automatic test_round_robin();
    default_data();
    s_tvalid = 4'hF;
    m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 4'b0001) begin failures++; $display("FAIL rr_first_ready got=%b exp=0001", s_tready); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (m_tvalid !== 1'b1 || m_tid !== IW'(k % N) || m_tdata !== (32'hA000_0000 | DW'(k % N))) begin
        failures++;
        $display("FAIL rr_beat%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                 k, m_tvalid, m_tid, m_tdata, k % N, 32'hA000_0000 | DW'(k % N));
      end
    end
    s_tvalid = 4'h0;
    tick();
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rr_idle_tvalid got=%b exp=0", m_tvalid); end
  endtask

  // last_grant=3 with ch0 and ch3 valid: the search wraps to ch0, then ch3.
  task automatic test_wrap();
    s_tvalid = 4'b1001;
    #1;
    checks++; if (s_tready !== 4'b0001) begin failures++; $display("FAIL wrap_ready0 got=%b exp=0001", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd0 || m_tdata !== 32'hA000_0000) begin failures++; $display("FAIL wrap_beat0 got v=%b id=%0d d=%h exp v=1 id=0 d=a0000000", m_tvalid, m_tid, m_tdata); end
    checks++; if (s_tready !== 4'b1000) begin failures++; $display("FAIL wrap_ready3 got=%b exp=1000", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd3 || m_tdata !== 32'hA000_0003) begin failures++; $display("FAIL wrap_beat3 got v=%b id=%0d d=%h exp v=1 id=3 d=a0000003", m_tvalid, m_tid, m_tdata); end
    s_tvalid = 4'h0;
    tick();
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b exp=0", m_tvalid); end
  endtask

  // Only ch2 valid: granted every cycle, other readies stay low.
  task automatic test_single_channel();
    s_tvalid = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      dat[2] = 32'h0000_0200 + DW'(k);
      #1;
      checks++; if (s_tready !== 4'b0100) begin failures++; $display("FAIL single_ready%0d got=%b exp=0100", k, s_tready); end
      tick();
      checks++;
      if (m_tvalid !== 1'b1 || m_tid !== 2'd2 || m_tdata !== 32'h0000_0200 + DW'(k)) begin
        failures++;
        $display("FAIL single_beat%0d got v=%b id=%0d d=%h exp v=1 id=2 d=%h",
                 k, m_tvalid, m_tid, m_tdata, 32'h0000_0200 + DW'(k));
      end
    end
    s_tvalid = 4'h0;
    default_data();
    tick();
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", m_tvalid); end
  endtask

  // Output held under m_tready=0: data/id stable, no slave ready, beat once.
  task automatic test_backpressure();
    dat[1]   = 32'h0000_1234;
    s_tvalid = 4'b0010;
    m_tready = 1'b1;
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd1 || m_tdata !== 32'h0000_1234) begin failures++; $display("FAIL bp_load got v=%b id=%0d d=%h exp v=1 id=1 d=00001234", m_tvalid, m_tid, m_tdata); end
    m_tready = 1'b0;
    s_tvalid = 4'hF;
    dat[1]   = 32'h0000_5555;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (s_tready !== 4'b0000) begin failures++; $display("FAIL bp_ready%0d got=%b exp=0000", k, s_tready); end
      tick();
      checks++;
      if (m_tvalid !== 1'b1 || m_tid !== 2'd1 || m_tdata !== 32'h0000_1234) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b id=%0d d=%h exp v=1 id=1 d=00001234", k, m_tvalid, m_tid, m_tdata);
      end
    end
    m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd2 || m_tdata !== 32'hA000_0002) begin failures++; $display("FAIL bp_next got v=%b id=%0d d=%h exp v=1 id=2 d=a0000002", m_tvalid, m_tid, m_tdata); end
    s_tvalid = 4'h0;
    default_data();
    tick();
    checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL bp_idle got=%b exp=0", m_tvalid); end
  endtask

  // Async reset while a beat is pending; arbitration restarts at ch0.
  task automatic test_reset_midstream();
    m_tready = 1'b0;
    s_tvalid = 4'b0100;
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd2) begin failures++; $display("FAIL rst_pending got v=%b id=%0d exp v=1 id=2", m_tvalid, m_tid); end
    aresetn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || m_tid !== 2'd0) begin failures++; $display("FAIL rst_async got v=%b id=%0d d=%h exp v=0 id=0 d=0", m_tvalid, m_tid, m_tdata); end
    checks++; if (s_tready !== 4'b0000) begin failures++; $display("FAIL rst_async_ready got=%b exp=0000", s_tready); end
    @(negedge aclk);
    aresetn  = 1'b1;
    s_tvalid = 4'b0011;
    m_tready = 1'b1;
    #1;
    checks++; if (s_tready !== 4'b0001) begin failures++; $display("FAIL rst_restart_ready got=%b exp=0001", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd0) begin failures++; $display("FAIL rst_first got v=%b id=%0d exp v=1 id=0", m_tvalid, m_tid); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd1) begin failures++; $display("FAIL rst_second got v=%b id=%0d exp v=1 id=1", m_tvalid, m_tid); end
    s_tvalid = 4'h0;
    tick();
  endtask

`ifdef AXIS_RR_MUX_TLAST_EN
  // ch1 sends a 3-beat packet with a 2-cycle gap; ch0 (single-beat packets)
  // stays valid and must not get in until the ch1 tlast beat is accepted.
  // Entered with last_grant=1, so ch0 wins first, then ch1 opens its packet.
  task automatic test_tlast_lock();
    s_tlast  = 4'b0001;
    dat[1]   = 32'hB100_0001;
    s_tvalid = 4'b0011;
    tick();
    checks++; if (m_tid !== 2'd0 || m_tlast !== 1'b1) begin failures++; $display("FAIL lock_ch0 got id=%0d last=%b exp id=0 last=1", m_tid, m_tlast); end
    checks++; if (s_tready !== 4'b0010) begin failures++; $display("FAIL lock_b1_ready got=%b exp=0010", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd1 || m_tdata !== 32'hB100_0001 || m_tlast !== 1'b0) begin failures++; $display("FAIL lock_b1 got v=%b id=%0d d=%h last=%b exp v=1 id=1 d=b1000001 last=0", m_tvalid, m_tid, m_tdata, m_tlast); end
    dat[1] = 32'hB100_0002;
    #1;
    checks++; if (s_tready !== 4'b0010) begin failures++; $display("FAIL lock_b2_ready got=%b exp=0010", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd1 || m_tdata !== 32'hB100_0002 || m_tlast !== 1'b0) begin failures++; $display("FAIL lock_b2 got v=%b id=%0d d=%h last=%b exp v=1 id=1 d=b1000002 last=0", m_tvalid, m_tid, m_tdata, m_tlast); end
    s_tvalid = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (s_tready !== 4'b0000) begin failures++; $display("FAIL lock_gap_ready%0d got=%b exp=0000", k, s_tready); end
      tick();
      checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL lock_gap%0d got v=%b id=%0d exp v=0", k, m_tvalid, m_tid); end
    end
    dat[1]   = 32'hB100_0003;
    s_tlast  = 4'b0011;
    s_tvalid = 4'b0011;
    #1;
    checks++; if (s_tready !== 4'b0010) begin failures++; $display("FAIL lock_b3_ready got=%b exp=0010", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd1 || m_tdata !== 32'hB100_0003 || m_tlast !== 1'b1) begin failures++; $display("FAIL lock_b3 got v=%b id=%0d d=%h last=%b exp v=1 id=1 d=b1000003 last=1", m_tvalid, m_tid, m_tdata, m_tlast); end
    s_tvalid = 4'b0001;
    #1;
    checks++; if (s_tready !== 4'b0001) begin failures++; $display("FAIL unlock_ready got=%b exp=0001", s_tready); end
    tick();
    checks++; if (m_tvalid !== 1'b1 || m_tid !== 2'd0 || m_tdata !== 32'hA000_0000) begin failures++; $display("FAIL unlock_ch0 got v=%b id=%0d d=%h exp v=1 id=0 d=a0000000", m_tvalid, m_tid, m_tdata); end
    s_tvalid = 4'h0;
    default_data();
    tick();
  endtask
`endif

  initial begin
    aresetn  = 1'b0;
    m_tready = 1'b0;
    s_tvalid = '0;
`ifdef AXIS_RR_MUX_TLAST_EN
    s_tlast  = '0;
`endif
    default_data();
    test_reset();
    test_round_robin();
    test_wrap();
    test_single_channel();
    test_backpressure();
    test_reset_midstream();
`ifdef AXIS_RR_MUX_TLAST_EN
    test_tlast_lock();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
